// File: rtl/bus_cycle_responder.sv
//------------------------------------------------------------------------------
// bus_cycle_responder
//
// Slave-side terminator for 68030 asynchronous bus cycles. The CPU opens a
// cycle with n_as/n_ds. This block decodes addr[31:24] into a region and
// drives that region's chip select and read/write strobes. It then counts
// the region's wait states and ends the cycle with n_dsack (which carries the
// port size) or with n_berr. It sits in the core glue logic between the CPU
// bus and the ROM, the on-board I/O and the expansion slots.
//
// Regions:
//   ROM  - addr == ROM_BASE, 32-bit port, cacheable,    n_dsack = 2'b00
//   IO   - addr == IO_BASE,   8-bit port, cache-inhib.,  n_dsack = 2'b10
//   EXP  - addr == EXP_BASE, 16-bit port, cache-inhib.,  n_dsack = 2'b01,
//          stretched by n_waite and can be failed with n_berre
//   NONE - any other address, terminated with n_berr
//
// Optional build macro: BUS_TIMEOUT_EN
//   defined   - a cycle-age counter counts the cycles spent in WAIT. When it
//               reaches TIMEOUT the cycle ends with a bus error. This covers
//               unmapped addresses and expansion cards that hold n_waite
//               forever.
//   undefined - unmapped addresses get a bus error on the first WAIT cycle,
//               and the expansion region waits on n_waite indefinitely.
//
// Ports:
//   clock     in   system clock
//   n_reset   in   synchronous active-low reset
//   n_as      in   CPU address strobe (asynchronous, active-low)
//   n_ds      in   CPU data strobe (asynchronous, active-low)
//   rn_w      in   1 = read, 0 = write (stable while n_as is low)
//   addr      in   CPU addr[31:24] (stable while n_as is low)
//   fc        in   CPU function code; 3'b111 = CPU space, not answered
//   n_waite   in   expansion wait request (asynchronous, active-low)
//   n_berre   in   expansion bus error (asynchronous, active-low)
//   n_dsack   out  cycle termination / port size, active-low, registered
//   n_berr    out  bus error, active-low, registered
//   n_ciin    out  cache inhibit, active-low, registered
//   n_rom     out  ROM chip select, active-low, registered
//   n_io      out  I/O chip select, active-low, registered
//   n_exp     out  expansion chip select, active-low, registered
//   n_read    out  read strobe for I/O and expansion, active-low, registered
//   n_write   out  write strobe for I/O and expansion, active-low, registered
//------------------------------------------------------------------------------
module bus_cycle_responder #(
   parameter logic [7:0]  ROM_BASE = 8'h00,
   parameter logic [7:0]  IO_BASE  = 8'h80,
   parameter logic [7:0]  EXP_BASE = 8'h90,
   parameter int unsigned ROM_WAIT = 2,
   parameter int unsigned IO_WAIT  = 4,
   parameter int unsigned EXP_WAIT = 1,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic       clock,
   input  logic       n_reset,
   input  logic       n_as,
   input  logic       n_ds,
   input  logic       rn_w,
   input  logic [7:0] addr,
   input  logic [2:0] fc,
   input  logic       n_waite,
   input  logic       n_berre,
   output logic [1:0] n_dsack,
   output logic       n_berr,
   output logic       n_ciin,
   output logic       n_rom,
   output logic       n_io,
   output logic       n_exp,
   output logic       n_read,
   output logic       n_write
);

   //---------------------------------------------------------------------------
   // Encodings
   //---------------------------------------------------------------------------
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WAIT    = 3'd1;
   localparam logic [2:0] ST_ACK     = 3'd2;
   localparam logic [2:0] ST_BERR    = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   localparam logic [1:0] RG_NONE = 2'd0;
   localparam logic [1:0] RG_ROM  = 2'd1;
   localparam logic [1:0] RG_IO   = 2'd2;
   localparam logic [1:0] RG_EXP  = 2'd3;

   localparam logic [2:0] FC_CPU_SPACE = 3'b111;

   // The wait counter only has to hold the largest per-region wait value.
   localparam int unsigned MAX_WAIT = (ROM_WAIT > IO_WAIT)
                                    ? ((ROM_WAIT > EXP_WAIT) ? ROM_WAIT : EXP_WAIT)
                                    : ((IO_WAIT  > EXP_WAIT) ? IO_WAIT  : EXP_WAIT);
   localparam int unsigned WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   //---------------------------------------------------------------------------
   // Region helpers
   //---------------------------------------------------------------------------
   function automatic logic [1:0] decode_region(input logic [7:0] a);
      logic [1:0] rg;
      rg = RG_NONE;
      if (a == ROM_BASE) begin
         rg = RG_ROM;
      end else if (a == IO_BASE) begin
         rg = RG_IO;
      end else if (a == EXP_BASE) begin
         rg = RG_EXP;
      end
      return rg;
   endfunction

   function automatic logic [WAIT_W-1:0] region_wait(input logic [1:0] rg);
      logic [WAIT_W-1:0] w;
      case (rg)
         RG_ROM:  w = WAIT_W'(ROM_WAIT);
         RG_IO:   w = WAIT_W'(IO_WAIT);
         RG_EXP:  w = WAIT_W'(EXP_WAIT);
         default: w = '0;
      endcase
      return w;
   endfunction

   //---------------------------------------------------------------------------
   // Input synchronisers (two flops each)
   //---------------------------------------------------------------------------
   logic [1:0] as_sync_q;
   logic [1:0] ds_sync_q;
   logic [1:0] waite_sync_q;
   logic [1:0] berre_sync_q;
   logic       as_s;
   logic       ds_s;
   logic       waite_s;
   logic       berre_s;

   // NOTE: The synchronisers are deliberately left out of the reset. If reset
   // loaded them with "negated", RELEASE would see a false as_s high just
   // after reset. It would then answer the cycle that was cut off.
   always_ff @(posedge clock) begin
      as_sync_q    <= {as_sync_q[0],    n_as};
      ds_sync_q    <= {ds_sync_q[0],    n_ds};
      waite_sync_q <= {waite_sync_q[0], n_waite};
      berre_sync_q <= {berre_sync_q[0], n_berre};
   end

   assign as_s    = as_sync_q[1];
   assign ds_s    = ds_sync_q[1];
   assign waite_s = waite_sync_q[1];
   assign berre_s = berre_sync_q[1];

   //---------------------------------------------------------------------------
   // Cycle state
   //---------------------------------------------------------------------------
   logic [2:0]        state_q,    state_d;
   logic [1:0]        region_q,   region_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

   // force_berr ends a WAIT cycle with a bus error that no expansion card
   // asked for.
   logic force_berr;

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned AGE_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [AGE_W-1:0] age_q, age_d;

   // Holding the counter at zero for all of IDLE clears it on IDLE exit.
   always_comb begin
      age_d = age_q;
      if (state_q == ST_IDLE) begin
         age_d = '0;
      end else if (state_q == ST_WAIT) begin
         age_d = age_q + AGE_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!n_reset) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end

   assign force_berr = (age_q == AGE_W'(TIMEOUT));
`else
   localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;

   // Without a timeout, an unmapped address can only be ended by a bus error
   // at once.
   assign force_berr = (region_q == RG_NONE);
`endif

   // NOTE: Every signal in this block is given a default first. This keeps
   // synthesis from inferring a latch for any state/region/counter path that
   // the case statement leaves unassigned.
   always_comb begin
      state_d    = state_q;
      region_d   = region_q;
      wait_cnt_d = wait_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (!as_s && (fc != FC_CPU_SPACE)) begin
               region_d   = decode_region(addr);
               wait_cnt_d = region_wait(region_d);
               state_d    = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (as_s) begin
               // The CPU gave up on the cycle. Drop it without a termination.
               state_d = ST_IDLE;
            end else if ((region_q == RG_EXP) && !berre_s) begin
               state_d = ST_BERR;
            end else if (force_berr) begin
               state_d = ST_BERR;
            end else if (wait_cnt_q != '0) begin
               wait_cnt_d = wait_cnt_q - WAIT_W'(1);
            end else if ((region_q != RG_NONE) &&
                         ((region_q != RG_EXP) || waite_s)) begin
               state_d = ST_ACK;
            end
         end

         ST_ACK, ST_BERR, ST_RELEASE: begin
            if (as_s) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_RELEASE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Output decode. The outputs are computed from the next state so that
   // they change on the same edge as the state register.
   //---------------------------------------------------------------------------
   logic [1:0] n_dsack_q, n_dsack_d;
   logic       n_berr_q,  n_berr_d;
   logic       n_ciin_q,  n_ciin_d;
   logic       n_rom_q,   n_rom_d;
   logic       n_io_q,    n_io_d;
   logic       n_exp_q,   n_exp_d;
   logic       n_read_q,  n_read_d;
   logic       n_write_q, n_write_d;
   logic       in_cycle;
   logic       strobe_en;

   always_comb begin
      in_cycle  = (state_d == ST_WAIT) || (state_d == ST_ACK) ||
                  (state_d == ST_BERR);
      // ROM has no strobes of its own; it decodes straight from its chip
      // select.
      strobe_en = ((state_d == ST_WAIT) || (state_d == ST_ACK)) &&
                  ((region_d == RG_IO) || (region_d == RG_EXP)) && !ds_s;

      n_rom_d   = !(in_cycle && (region_d == RG_ROM));
      n_io_d    = !(in_cycle && (region_d == RG_IO));
      n_exp_d   = !(in_cycle && (region_d == RG_EXP));
      n_ciin_d  = !(in_cycle && (region_d != RG_ROM));
      n_read_d  = !(strobe_en &&  rn_w);
      n_write_d = !(strobe_en && !rn_w);
      n_berr_d  = (state_d != ST_BERR);

      n_dsack_d = 2'b11;
      if (state_d == ST_ACK) begin
         case (region_d)
            RG_ROM:  n_dsack_d = 2'b00;
            RG_IO:   n_dsack_d = 2'b10;
            RG_EXP:  n_dsack_d = 2'b01;
            default: n_dsack_d = 2'b11;
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   // NOTE: The sequential state uses non-blocking assignments. This way every
   // flop samples the values from before the edge, whatever the order the
   // statements are written in.
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         // RELEASE makes a reset that lands mid-cycle skip the rest of it.
         state_q    <= ST_RELEASE;
         region_q   <= RG_NONE;
         wait_cnt_q <= '0;
         n_dsack_q  <= 2'b11;
         n_berr_q   <= 1'b1;
         n_ciin_q   <= 1'b1;
         n_rom_q    <= 1'b1;
         n_io_q     <= 1'b1;
         n_exp_q    <= 1'b1;
         n_read_q   <= 1'b1;
         n_write_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         region_q   <= region_d;
         wait_cnt_q <= wait_cnt_d;
         n_dsack_q  <= n_dsack_d;
         n_berr_q   <= n_berr_d;
         n_ciin_q   <= n_ciin_d;
         n_rom_q    <= n_rom_d;
         n_io_q     <= n_io_d;
         n_exp_q    <= n_exp_d;
         n_read_q   <= n_read_d;
         n_write_q  <= n_write_d;
      end
   end

   assign n_dsack = n_dsack_q;
   assign n_berr  = n_berr_q;
   assign n_ciin  = n_ciin_q;
   assign n_rom   = n_rom_q;
   assign n_io    = n_io_q;
   assign n_exp   = n_exp_q;
   assign n_read  = n_read_q;
   assign n_write = n_write_q;

endmodule

// File: tb/tb_bus_cycle_responder.sv
//------------------------------------------------------------------------------
// tb_bus_cycle_responder
//
// Self-checking bench for bus_cycle_responder. Each scenario starts a CPU
// cycle and pushes the expected termination (the output vector and the edge
// latency) onto a scoreboard queue. The entry is popped and compared when
// the DUT terminates the cycle. Inputs change 1 ns after a rising edge.
// Outputs are sampled on the falling edge.
//------------------------------------------------------------------------------
module tb_bus_cycle_responder;

   localparam int unsigned ROM_WAIT = 2;
   localparam int unsigned IO_WAIT  = 4;
   localparam int unsigned EXP_WAIT = 1;
   // Two synchroniser edges pass before as_s is low. One more edge enters
   // WAIT, and a final edge registers the termination.
   localparam int unsigned OVERHEAD = 4;
`ifdef BUS_TIMEOUT_EN
   localparam int unsigned TIMEOUT  = 255;
   localparam int unsigned NONE_LAT = OVERHEAD + TIMEOUT;
`else
   localparam int unsigned NONE_LAT = OVERHEAD;
`endif
   localparam int unsigned TERM_BUDGET = 400;
   localparam logic [8:0]  ALL_HIGH    = 9'h1FF;

   logic       clock   = 1'b0;
   logic       n_reset = 1'b0;
   logic       n_as    = 1'b1;
   logic       n_ds    = 1'b1;
   logic       rn_w    = 1'b1;
   logic [7:0] addr    = 8'h00;
   logic [2:0] fc      = 3'b101;
   logic       n_waite = 1'b1;
   logic       n_berre = 1'b1;
   logic [1:0] n_dsack;
   logic       n_berr, n_ciin, n_rom, n_io, n_exp, n_read, n_write;

   int          checks   = 0;
   int          errors   = 0;
   int unsigned edge_cnt = 0;
   int unsigned cyc_start;
   logic [8:0]  last_vec;

   typedef struct {
      logic [8:0]  vec;   // {n_dsack, n_berr, n_rom, n_io, n_exp, n_ciin, n_read, n_write}
      int unsigned lat;   // edges from the n_as-low edge to the termination
   } exp_t;

   exp_t sb_q[$];

   bus_cycle_responder dut (
      .clock   (clock),
      .n_reset (n_reset),
      .n_as    (n_as),
      .n_ds    (n_ds),
      .rn_w    (rn_w),
      .addr    (addr),
      .fc      (fc),
      .n_waite (n_waite),
      .n_berre (n_berre),
      .n_dsack (n_dsack),
      .n_berr  (n_berr),
      .n_ciin  (n_ciin),
      .n_rom   (n_rom),
      .n_io    (n_io),
      .n_exp   (n_exp),
      .n_read  (n_read),
      .n_write (n_write)
   );

   always #5 clock = ~clock;

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [8:0] outs();
      return {n_dsack, n_berr, n_rom, n_io, n_exp, n_ciin, n_read, n_write};
   endfunction

   // Reference model: the termination vector and latency for a cycle that
   // is not stretched.
   function automatic exp_t model(input logic [7:0] a, input logic rw);
      exp_t e;
      case (a)
         8'h00: begin
            e.vec = {2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            e.lat = OVERHEAD + ROM_WAIT;
         end
         8'h80: begin
            e.vec = {2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ~rw, rw};
            e.lat = OVERHEAD + IO_WAIT;
         end
         8'h90: begin
            e.vec = {2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ~rw, rw};
            e.lat = OVERHEAD + EXP_WAIT;
         end
         default: begin
            e.vec = {2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
            e.lat = NONE_LAT;
         end
      endcase
      return e;
   endfunction

   // Returns 1 ns after rising edge number "target".
   task automatic goto_drive(input int unsigned target);
      while (edge_cnt < target) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Returns on the falling edge that follows rising edge number "target".
   task automatic goto_sample(input int unsigned target);
      do @(negedge clock); while (edge_cnt < target);
   endtask

   task automatic start_cycle(input logic [7:0] a, input logic [2:0] f, input logic rw);
      @(posedge clock);
      #1;
      addr = a;
      fc   = f;
      rn_w = rw;
      n_as = 1'b0;
      n_ds = 1'b0;
      cyc_start = edge_cnt;
   endtask

   // Scoreboard consumer: waits for the DUT to terminate, then pops the
   // matching expectation and compares it.
   task automatic sb_pop_compare(input string name);
      exp_t        e;
      bit          seen;
      int unsigned lat;
      seen = 1'b0;
      for (int unsigned i = 0; i < TERM_BUDGET && !seen; i++) begin
         @(negedge clock);
         if (n_dsack !== 2'b11 || n_berr !== 1'b1) seen = 1'b1;
      end
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s: termination seen with no expectation queued", name);
         return;
      end
      e = sb_q.pop_front();
      last_vec = e.vec;
      if (!seen) begin
         errors++;
         $display("FAIL %s: no termination within %0d cycles, outputs=%b required=%b",
                  name, TERM_BUDGET, outs(), e.vec);
         return;
      end
      if (outs() !== e.vec) begin
         errors++;
         $display("FAIL %s: outputs=%b required=%b", name, outs(), e.vec);
      end
      lat = edge_cnt - cyc_start;
      checks++;
      if (lat !== e.lat) begin
         errors++;
         $display("FAIL %s latency: got %0d edges, required %0d", name, lat, e.lat);
      end
   endtask

   // Raises n_as. The termination must stay up for two more edges and drop
   // on the third.
   task automatic release_cycle(input string name);
      int unsigned rel;
      @(posedge clock);
      #1;
      n_as = 1'b1;
      n_ds = 1'b1;
      rel  = edge_cnt;
      goto_sample(rel + 2);
      checks++;
      if (outs() !== last_vec) begin
         errors++;
         $display("FAIL %s hold: outputs=%b required=%b", name, outs(), last_vec);
      end
      goto_sample(rel + 3);
      checks++;
      if (outs() !== ALL_HIGH) begin
         errors++;
         $display("FAIL %s negate: outputs=%b required=%b", name, outs(), ALL_HIGH);
      end
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (outs() !== ALL_HIGH) begin
         errors++;
         $display("FAIL reset_state: outputs=%b required=%b", outs(), ALL_HIGH);
      end
      n_reset = 1'b1;
      repeat (4) @(negedge clock);
      checks++;
      if (outs() !== ALL_HIGH) begin
         errors++;
         $display("FAIL reset_idle: outputs=%b required=%b", outs(), ALL_HIGH);
      end
   endtask

   task automatic test_rom_read();
      start_cycle(8'h00, 3'b101, 1'b1);
      sb_q.push_back(model(8'h00, 1'b1));
      sb_pop_compare("rom_read");
      release_cycle("rom_read");
   endtask

   task automatic test_io_write();
      start_cycle(8'h80, 3'b101, 1'b0);
      sb_q.push_back(model(8'h80, 1'b0));
      sb_pop_compare("io_write");
      release_cycle("io_write");
   endtask

   task automatic test_exp_waite();
      exp_t e;
      start_cycle(8'h90, 3'b101, 1'b1);
      n_waite = 1'b0;
      e = model(8'h90, 1'b1);
      // n_waite rises 10 edges in. waite_s follows 2 edges later, and the
      // ACK is registered on the edge after that.
      e.lat = 10 + 3;
      sb_q.push_back(e);
      goto_sample(cyc_start + 6);
      checks++;
      if (outs() !== {2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL exp_waite_wait: outputs=%b required=%b", outs(),
                  {2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      goto_drive(cyc_start + 10);
      n_waite = 1'b1;
      goto_sample(cyc_start + 12);
      checks++;
      if (n_dsack !== 2'b11) begin
         errors++;
         $display("FAIL exp_waite_early: n_dsack=%b required=11", n_dsack);
      end
      sb_pop_compare("exp_waite");
      release_cycle("exp_waite");
   endtask

   task automatic test_exp_berre();
      exp_t e;
      start_cycle(8'h90, 3'b101, 1'b1);
      n_waite = 1'b0;
      e.vec = {2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      // berre pulses low after edge 5. berre_s is low at edge 7, and BERR is
      // registered at edge 8.
      e.lat = 5 + 3;
      sb_q.push_back(e);
      goto_drive(cyc_start + 5);
      n_berre = 1'b0;
      goto_drive(cyc_start + 7);
      n_berre = 1'b1;
      sb_pop_compare("exp_berre");
      release_cycle("exp_berre");
      n_waite = 1'b1;
   endtask

   task automatic test_unmapped();
      start_cycle(8'h40, 3'b101, 1'b1);
      sb_q.push_back(model(8'h40, 1'b1));
      sb_pop_compare("unmapped");
      release_cycle("unmapped");
   endtask

   task automatic test_cpu_space();
      bit quiet;
      start_cycle(8'h00, 3'b111, 1'b1);
      quiet = 1'b1;
      repeat (20) begin
         @(negedge clock);
         if (outs() !== ALL_HIGH) quiet = 1'b0;
      end
      checks++;
      if (!quiet) begin
         errors++;
         $display("FAIL cpu_space: outputs=%b required=%b", outs(), ALL_HIGH);
      end
      @(posedge clock);
      #1;
      n_as = 1'b1;
      n_ds = 1'b1;
      fc   = 3'b101;
      repeat (4) @(posedge clock);
   endtask

   task automatic test_abort();
      bit terminated;
      start_cycle(8'h80, 3'b101, 1'b1);
      goto_sample(cyc_start + 3);
      checks++;
      if ({n_io, n_read, n_ciin} !== 3'b000) begin
         errors++;
         $display("FAIL abort_select: {n_io,n_read,n_ciin}=%b required=000",
                  {n_io, n_read, n_ciin});
      end
      goto_drive(cyc_start + 4);
      n_as = 1'b1;
      n_ds = 1'b1;
      terminated = 1'b0;
      while (edge_cnt < cyc_start + 18) begin
         @(negedge clock);
         if (n_dsack !== 2'b11 || n_berr !== 1'b1) terminated = 1'b1;
      end
      checks++;
      if (terminated || outs() !== ALL_HIGH) begin
         errors++;
         $display("FAIL abort: terminated=%0d outputs=%b required no termination and %b",
                  terminated, outs(), ALL_HIGH);
      end
   endtask

   task automatic test_reset_in_ack();
      bit quiet;
      start_cycle(8'h00, 3'b101, 1'b1);
      sb_q.push_back(model(8'h00, 1'b1));
      sb_pop_compare("pre_reset_rom");
      @(posedge clock);
      #1;
      n_reset = 1'b0;
      @(posedge clock);
      #1;
      n_reset = 1'b1;
      checks++;
      if (outs() !== ALL_HIGH) begin
         errors++;
         $display("FAIL reset_in_ack: outputs=%b required=%b", outs(), ALL_HIGH);
      end
      quiet = 1'b1;
      repeat (10) begin
         @(negedge clock);
         if (outs() !== ALL_HIGH) quiet = 1'b0;
      end
      checks++;
      if (!quiet) begin
         errors++;
         $display("FAIL reset_release_quiet: outputs=%b required=%b", outs(), ALL_HIGH);
      end
      @(posedge clock);
      #1;
      n_as = 1'b1;
      n_ds = 1'b1;
      repeat (5) @(posedge clock);
      start_cycle(8'h00, 3'b101, 1'b1);
      sb_q.push_back(model(8'h00, 1'b1));
      sb_pop_compare("post_reset_rom");
      release_cycle("post_reset_rom");
   endtask

   task automatic test_back_to_back();
      logic [7:0] tbl_addr [5];
      logic       tbl_rw   [5];
      tbl_addr = '{8'h80, 8'h90, 8'h00, 8'h90, 8'h40};
      tbl_rw   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         start_cycle(tbl_addr[i], 3'b001, tbl_rw[i]);
         sb_q.push_back(model(tbl_addr[i], tbl_rw[i]));
         sb_pop_compare($sformatf("b2b_%0d", i));
         release_cycle($sformatf("b2b_%0d", i));
         repeat ($urandom_range(0, 2)) @(posedge clock);
      end
   endtask

   initial begin
      test_reset();
      test_rom_read();
      test_io_write();
      test_exp_waite();
      test_exp_berre();
      test_unmapped();
      test_cpu_space();
      test_abort();
      test_reset_in_ack();
      test_back_to_back();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
